// File: rtl/pipeline_pkg.sv
// Purpose: shared MIPS pipeline constants and the fetch FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: branch/jump opcodes that branch_detection decodes, the NOP
//           word, and the state type of the fetch stage controller.
package pipeline_pkg;

   localparam logic [5:0]  OPC_BEQ   = 6'b000100;
   localparam logic [5:0]  OPC_BNE   = 6'b000101;
   localparam logic [5:0]  OPC_J     = 6'b000010;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_REDIR = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Purpose: program counter register with load, hold, +4 increment and wrap.
// Latency: 1 cycle (new PC visible after the clock edge).
// Backpressure: inc=0 holds the PC; load takes priority over inc.
// Ports: clk, rst (sync, active high), load/load_pc (redirect target,
//        word aligned internally), inc (advance by 4), pc (current PC).
module pc_counter #(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   // Instruction addresses are word aligned: the two low bits are cleared.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_pc & ALIGN_MASK;
      end else if (inc) begin
         pc <= pc + ADDR_W'(4);    // wraps modulo 2^ADDR_W
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Purpose: MIPS instruction-fetch stage; owns the PC, drives imem, loads IF/ID.
// Latency: address issued at edge k reaches IF/ID at edge k+2; 1 instr/cycle.
// Backpressure: stall_i holds PC, in-flight slot and IF/ID; redirect_i overrides stall_i.
// Ports: clk, rst (sync active high), stall_i, redirect_i/redirect_pc_i,
//        imem_en_o/imem_addr_o/imem_data_i (1-cycle synchronous memory),
//        ifid_instr_o/ifid_opcode_o/ifid_pc4_o/ifid_valid_o (IF/ID register).
// Option: define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction on a
//         redirect; otherwise it is squashed along with the wrong-path fetch.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              imem_en_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [31:0]       imem_data_i,
   output logic [31:0]       ifid_instr_o,
   output logic [5:0]        ifid_opcode_o,
   output logic [ADDR_W-1:0] ifid_pc4_o,
   output logic              ifid_valid_o
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_pc_q;
   logic              inflight_vld_q;
   logic              slot_vld;

   // imem_data_i carries a real instruction only once a fetch has been issued
   // on the correct path. In STALL the memory output is frozen, so validity is
   // whatever it was when the stall began (a stall straight out of BOOT or
   // REDIR holds an empty slot).
   assign slot_vld = (state_q == ST_RUN) ||
                     ((state_q == ST_STALL) && inflight_vld_q);

   assign imem_addr_o   = pc_q;
   assign imem_en_o     = !stall_i || redirect_i;
   assign ifid_opcode_o = ifid_instr_o[31:26];

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk     (clk),
      .rst     (rst),
      .load    (redirect_i),
      .load_pc (redirect_pc_i),
      .inc     (!stall_i),
      .pc      (pc_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_BOOT;
         inflight_vld_q <= 1'b0;
         inflight_pc_q  <= RESET_PC;
         ifid_instr_o   <= NOP_INSTR;
         ifid_pc4_o     <= '0;
         ifid_valid_o   <= 1'b0;
      end else if (redirect_i) begin
         // The fetch issued at the old pc_q this edge is wrong-path; the slot
         // is marked empty so the next edge loads a bubble.
`ifdef BRANCH_DELAY_SLOT_EN
         if (slot_vld) begin
            ifid_instr_o <= imem_data_i;
            ifid_pc4_o   <= inflight_pc_q + ADDR_W'(4);
            ifid_valid_o <= 1'b1;
         end else begin
            ifid_instr_o <= NOP_INSTR;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
         end
`else
         ifid_instr_o   <= NOP_INSTR;
         ifid_pc4_o     <= '0;
         ifid_valid_o   <= 1'b0;
`endif
         inflight_vld_q <= 1'b0;
         state_q        <= ST_REDIR;
      end else if (stall_i) begin
         inflight_vld_q <= slot_vld;
         state_q        <= ST_STALL;
      end else begin
         if (slot_vld) begin
            ifid_instr_o <= imem_data_i;
            ifid_pc4_o   <= inflight_pc_q + ADDR_W'(4);
            ifid_valid_o <= 1'b1;
         end else begin
            ifid_instr_o <= NOP_INSTR;
            ifid_pc4_o   <= '0;
            ifid_valid_o <= 1'b0;
         end
         inflight_pc_q  <= pc_q;
         inflight_vld_q <= 1'b1;
         state_q        <= ST_RUN;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed self-checking bench for fetch_stage.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_stage;
   import pipeline_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_en_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i = 32'h0;
   logic [31:0] ifid_instr_o;
   logic [5:0]  ifid_opcode_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] BEQ_WORD = 32'h1000_0008;
   localparam logic [31:0] J_WORD   = 32'h0800_0018;

   always #5 clk = ~clk;

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_en_o     (imem_en_o),
      .imem_addr_o   (imem_addr_o),
      .imem_data_i   (imem_data_i),
      .ifid_instr_o  (ifid_instr_o),
      .ifid_opcode_o (ifid_opcode_o),
      .ifid_pc4_o    (ifid_pc4_o),
      .ifid_valid_o  (ifid_valid_o)
   );

   // Memory contents: word[n] = n, except a BEQ at 0x20 and a J at 0x60.
   function automatic logic [31:0] memf(input logic [31:0] addr);
      if (addr == 32'h20) return BEQ_WORD;
      if (addr == 32'h60) return J_WORD;
      return {2'b00, addr[31:2]};
   endfunction

   // Synchronous instruction memory: output held while not enabled.
   always @(posedge clk) begin
      if (imem_en_o) imem_data_i <= memf(imem_addr_o);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic vld, input logic [31:0] instr,
                           input logic [31:0] pc4);
      chk({tag, ".valid"}, 32'(ifid_valid_o), 32'(vld));
      chk({tag, ".instr"}, ifid_instr_o, instr);
      chk({tag, ".pc4"},   ifid_pc4_o, pc4);
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      step(); step();
      // Reset state
      chk_ifid("reset", 1'b0, NOP_INSTR, 32'h0);
      chk("reset.pc", imem_addr_o, 32'h0);
      chk("reset.en", 32'(imem_en_o), 32'h1);

      // Free-running stream
      rst = 1'b0;
      step();
      chk("run1.valid", 32'(ifid_valid_o), 32'h0);
      chk("run1.pc", imem_addr_o, 32'h4);
      step(); chk_ifid("run2", 1'b1, 32'd0, 32'd4);
      chk("run2.pc", imem_addr_o, 32'h8);
      step(); chk_ifid("run3", 1'b1, 32'd1, 32'd8);
      step(); chk_ifid("run4", 1'b1, 32'd2, 32'd12);
      chk("run4.pc", imem_addr_o, 32'h10);

      // Stall for three cycles
      stall_i = 1'b1;
      #1;
      chk("stall.en", 32'(imem_en_o), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid("stall", 1'b1, 32'd2, 32'd12);
         chk("stall.pc", imem_addr_o, 32'h10);
      end
      stall_i = 1'b0;
      for (int n = 3; n <= 7; n++) begin
         step(); chk_ifid("resume", 1'b1, 32'(n), 32'(4 * (n + 1)));
      end
      step(); chk_ifid("beq", 1'b1, BEQ_WORD, 32'h24);
      chk("beq.opcode", 32'(ifid_opcode_o), 32'(OPC_BEQ));

      // Taken branch to 0x40
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      step();
`ifdef BRANCH_DELAY_SLOT_EN
      chk_ifid("br.slot", 1'b1, 32'd9, 32'h28);
`else
      chk_ifid("br.bub1", 1'b0, NOP_INSTR, 32'h0);
`endif
      chk("br.pc", imem_addr_o, 32'h40);
      redirect_i = 1'b0;
      step(); chk_ifid("br.bub2", 1'b0, NOP_INSTR, 32'h0);
      step(); chk_ifid("br.target", 1'b1, 32'h10, 32'h44);

      // Redirect and stall together: redirect wins, target aligned
      redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h103;
      #1;
      chk("rs.en", 32'(imem_en_o), 32'h1);
      step();
      chk("rs.pc", imem_addr_o, 32'h100);
`ifdef BRANCH_DELAY_SLOT_EN
      chk_ifid("rs.slot", 1'b1, 32'h11, 32'h48);
`else
      chk("rs.valid", 32'(ifid_valid_o), 32'h0);
`endif
      redirect_i = 1'b0; stall_i = 1'b0;
      step(); chk("rs.bub", 32'(ifid_valid_o), 32'h0);
      chk("rs.pc2", imem_addr_o, 32'h104);
      step(); chk_ifid("rs.target", 1'b1, 32'h40, 32'h104);

      // PC wrap-around
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
      step(); chk("wrap.pc0", imem_addr_o, 32'hFFFF_FFF8);
      redirect_i = 1'b0;
      step(); chk("wrap.pc1", imem_addr_o, 32'hFFFF_FFFC);
      step(); chk("wrap.pc2", imem_addr_o, 32'h0);
      chk_ifid("wrap.a", 1'b1, 32'h3FFF_FFFE, 32'hFFFF_FFFC);
      step(); chk_ifid("wrap.b", 1'b1, 32'h3FFF_FFFF, 32'h0);

      // Reset while a J sits in IF/ID, with a redirect also requested
      redirect_i = 1'b1; redirect_pc_i = 32'h60;
      step();
      redirect_i = 1'b0;
      step();
      step(); chk_ifid("j", 1'b1, J_WORD, 32'h64);
      chk("j.opcode", 32'(ifid_opcode_o), 32'(OPC_J));
      rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80;
      step();
      chk_ifid("rst2", 1'b0, NOP_INSTR, 32'h0);
      chk("rst2.pc", imem_addr_o, 32'h0);
      rst = 1'b0; redirect_i = 1'b0;
      step(); chk("rst2.run1", 32'(ifid_valid_o), 32'h0);
      step(); chk_ifid("rst2.run2", 1'b1, 32'd0, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
